uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester (fetch=0, core=1) round-robin arbiter sharing one UART transmitter.
// Optional SEND watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       lock0,
  input  logic       tx_en0,
  input  logic [7:0] tx_data0,
  output logic       gnt0,
  output logic       done0,
  input  logic       req1,
  input  logic       lock1,
  input  logic       tx_en1,
  input  logic [7:0] tx_data1,
  output logic       gnt1,
  output logic       done1,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_done,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, OWN, SEND} state_t;

  state_t     state_q;
  logic       owner_q;
  logic       last_q;
  logic       gnt0_q, gnt1_q;
  logic       done0_q, done1_q;
  logic       tx_en_q;
  logic [7:0] tx_data_q;
  logic       busy_q;

  logic       pick;
  logic       own_req, own_lock, own_tx_en;
  logic [7:0] own_data;

  // On a tie the requester that was not served last wins.
  assign pick      = (req0 && req1) ? ~last_q : req1;
  assign own_req   = owner_q ? req1     : req0;
  assign own_lock  = owner_q ? lock1    : lock0;
  assign own_tx_en = owner_q ? tx_en1   : tx_en0;
  assign own_data  = owner_q ? tx_data1 : tx_data0;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        err_q;
  logic        timeout_hit;

  assign timeout_hit = (cnt_q == (TIMEOUT_CYCLES - 16'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == OWN && own_tx_en) begin
      cnt_d = 16'd0;
    end else if (state_q == SEND) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tx_en_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q <= OWN;
            owner_q <= pick;
            gnt0_q  <= ~pick;
            gnt1_q  <= pick;
            busy_q  <= 1'b1;
          end
        end
        OWN: begin
          if (own_tx_en) begin
            tx_data_q <= own_data;
            tx_en_q   <= 1'b1;
            state_q   <= SEND;
          end else if (!own_req && !own_lock) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
          end
        end
        SEND: begin
          // A completed byte takes priority over a simultaneous watchdog expiry.
          if (uart_tx_done) begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            if (own_lock) begin
              state_q <= OWN;
            end else begin
              state_q <= IDLE;
              gnt0_q  <= 1'b0;
              gnt1_q  <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= owner_q;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;
  assign busy         = busy_q;

endmodule
